// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared CPU types (opcodes, SPECIAL function codes, mul/div op and FSM state).
// Rev 1.1
`default_nettype none

package mips_cpu_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    F_SLL   = 6'h00,
    F_JR    = 6'h08,
    F_MFHI  = 6'h10,
    F_MTHI  = 6'h11,
    F_MFLO  = 6'h12,
    F_MTLO  = 6'h13,
    F_MULT  = 6'h18,
    F_MULTU = 6'h19,
    F_DIV   = 6'h1A,
    F_DIVU  = 6'h1B,
    F_ADDU  = 6'h21,
    F_SUBU  = 6'h23
  } funct_t;

  // Codes 6 and 7 are left undefined and act as no-ops in the mul/div unit.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } muldiv_state_t;

  function automatic logic [2:0] funct_to_muldiv(input funct_t f);
    case (f)
      F_MULT:  return MD_MULT;
      F_MULTU: return MD_MULTU;
      F_DIV:   return MD_DIV;
      F_DIVU:  return MD_DIVU;
      F_MTHI:  return MD_MTHI;
      F_MTLO:  return MD_MTLO;
      default: return 3'b111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative HI/LO multiply/divide unit (shift-add / restoring, WIDTH steps).
// Rev 1.1
`default_nettype none

module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_FIX = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // MUL: {partial product high, multiplier/product low}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               nrem_q, nrem_d;
  logic               bzero_q, bzero_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;

  assign signed_op = SIGNED_FIX && ((op == MD_MULT) || (op == MD_DIV));
  assign sign_a    = signed_op & a[WIDTH-1];
  assign sign_b    = signed_op & b[WIDTH-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      nrem_q   <= 1'b0;
      bzero_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      nrem_q   <= nrem_d;
      bzero_q  <= bzero_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    nrem_d   = nrem_q;
    bzero_d  = bzero_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, mag_b};
              opnd_d   = mag_a;
              is_div_d = 1'b0;
              neg_d    = sign_a ^ sign_b;
            end
            MD_DIV, MD_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, mag_a};
              opnd_d   = mag_b;
              a_d      = a;
              is_div_d = 1'b1;
              neg_d    = sign_a ^ sign_b;
              nrem_d   = sign_a;
              bzero_d  = (b == '0);
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end else if (bzero_q) begin
          // Divide by zero yields all-ones quotient and the dividend as remainder.
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = nrem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed plus randomized checks of the mul/div unit against an arithmetic model.
// Rev 1.1
`default_nettype none

module tb_mips_cpu_muldiv;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mips_cpu_muldiv #(.WIDTH(32), .SIGNED_FIX(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Architectural result {hi, lo} of one operation, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 32'd0)                                 r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else                                            r = {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else            r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Model: pending result becomes visible WIDTH+1 enabled edges after the start edge.
  bit          m_valid = 1'b0;
  int          m_left  = 0;
  logic        m_done  = 1'b0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;
  logic [63:0] m_pend  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_done  = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
    end else if (clk_enable) begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done       = 1'b1;
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          m_pend = ref_result(op, a, b);
          m_left = 33;
        end else if (op == 3'd4) begin
          m_hi = a;
        end else if (op == 3'd5) begin
          m_lo = a;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi",   64'(hi),   64'(m_hi));
      chk("lo",   64'(lo),   64'(m_lo));
    end
  end

  // Issues one op, scrambles the operand inputs afterwards, optionally pokes start mid-flight
  // and gates clk_enable for 5 cycles, then checks latency and literal result.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit poke, input int gate_at,
                        input int exp_edges, input logic [31:0] eh, input logic [31:0] el);
    int n;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    n     = 0;
    while (!done && n < 100) begin
      if (poke && n == 5) begin
        start = 1'b1;
        op    = 3'd0;
        a     = 32'd3;
        b     = 32'd4;
      end
      if (poke && n == 8) start = 1'b0;
      if (n == gate_at)     clk_enable = 1'b0;
      if (n == gate_at + 5) clk_enable = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    clk_enable = 1'b1;
    chk({nm, "_latency"}, 64'(n), 64'(exp_edges));
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    int          n;
    bit          seen_done;

    reset      = 1'b1;
    clk_enable = 1'b1;
    start      = 1'b0;
    op         = 3'd0;
    a          = '0;
    b          = '0;

    // Hand-computed values that pin the reference model itself.
    r = ref_result(3'd0, 32'hFFFFFFFF, 32'd2);
    chk("model_mult", r, 64'hFFFFFFFF_FFFFFFFE);
    r = ref_result(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("model_multu", r, 64'hFFFFFFFE_00000001);
    r = ref_result(3'd2, 32'hFFFFFFF9, 32'd2);
    chk("model_div_neg", r, 64'hFFFFFFFF_FFFFFFFD);
    r = ref_result(3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("model_div_ovf", r, 64'h00000000_80000000);
    r = ref_result(3'd3, 32'd7, 32'd0);
    chk("model_divu_zero", r, 64'h00000007_FFFFFFFF);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);

    run_op("mult",    3'd0, 32'hFFFFFFFF, 32'd2,        1'b0, -10, 33, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -10, 33, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, -10, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, -10, 33, 32'h00000000, 32'h80000000);
    run_op("divu_z",  3'd3, 32'd7,        32'd0,        1'b0, -10, 33, 32'h00000007, 32'hFFFFFFFF);

    op    = 3'd4;
    a     = 32'h12345678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h12345678);
    chk("mthi_busy", 64'(busy), 64'h0);
    run_op("mult_poke", 3'd0, 32'h1234, 32'h5678, 1'b1, -10, 33, 32'h0, 32'h06260060);

    // Reset ten cycles into a multiply must abandon it without a done pulse.
    op    = 3'd0;
    a     = 32'hDEADBEEF;
    b     = 32'h00000FFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_hi", 64'(hi), 64'h0);
    chk("rst_mid_lo", 64'(lo), 64'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("rst_mid_no_done", 64'(seen_done), 64'h0);

    run_op("div_gated", 3'd2, 32'd100, 32'd7, 1'b0, 10, 38, 32'd2, 32'd14);

    for (n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      clk_enable = ($urandom_range(0, 9) != 0);
      start      = ($urandom_range(0, 3) == 0);
      op         = 3'($urandom_range(0, 7));
      a          = pick();
      b          = pick();
      @(posedge clk); #1;
    end
    reset      = 1'b0;
    clk_enable = 1'b1;
    start      = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
